reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; next generation of the 8x16 two-read/one-write register file.
- Adds configurable width, depth and read-port count, byte-enable writes, optional write-to-read bypass, and an optional hardwired-zero entry 0.
- Adds a sequential clear engine that sweeps the array one entry per cycle with a busy/done handshake.
- Sits in the datapath as the operand store between decode and ALU.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of combinational read ports, 1..4.
- ZERO_REG, 0, when 1 entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1 a read of the address being written this cycle returns the new merged data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_be  in  WIDTH/8  byte enables; bit k covers d_in[8k+7:8k].
- d_in  in  WIDTH  write data.
- rd_addr  in  NRD*AW  packed read addresses; port p at [p*AW +: AW].
- d_out  out  NRD*WIDTH  packed read data; port p at [p*WIDTH +: WIDTH].
- clr_start  in  1  single-cycle request to start a clear sweep.
- busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- wr_err  out  1  registered; high for one cycle after a write is rejected.

Behaviour:
- Reset (reset=0, async):
  - All entries = 0; FSM = IDLE.
  - busy=0, clr_done=0, wr_err=0, clear pointer = 0.
  - Release is synchronous to the next clk edge.
- Write:
  - On posedge with wr=1, FSM IDLE, and not (ZERO_REG && wr_addr==0): each byte k with wr_be[k]=1 is updated from d_in.
  - Bytes with wr_be[k]=0 keep their value.
  - wr_be=0 is a legal no-op.
- Read:
  - Combinational; d_out[p] = mem[rd_addr[p]].
  - ZERO_REG && rd_addr[p]==0 forces 0, which overrides bypass.
- Bypass (BYPASS=1):
  - Applies when wr is accepted this cycle and rd_addr[p]==wr_addr.
  - d_out[p] = mem[wr_addr] with enabled bytes replaced by d_in, i.e. the post-write value, same cycle.
  - BYPASS=0: read returns the pre-write value until the edge.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_start=1 -> CLEAR, ptr<=0, busy<=1.
  - CLEAR: each cycle mem[ptr]<=0, ptr<=ptr+1. When ptr==DEPTH-1, that entry is written, then -> DONE.
  - DONE: clr_done=1 and busy<=0 for exactly one cycle, then -> IDLE.
  - A sweep takes DEPTH cycles in CLEAR; busy is high for DEPTH cycles.
  - clr_start while busy or in DONE is ignored; no restart.
  - clr_start and wr in the same IDLE cycle: the write is performed, and the clear starts next cycle and overwrites it.
- Writes during CLEAR or DONE: dropped; wr_err=1 on the following cycle.
- Reads during CLEAR: return current array contents. Entries not yet swept keep old values; bypass is disabled.
- Writes to entry 0 with ZERO_REG=1: silently dropped; wr_err stays 0.
- Reset asserted mid-sweep: array zeroed, FSM to IDLE, no clr_done pulse.
- Address wrap: the pointer is compared to DEPTH-1 and never wraps past it.

Decomposition:
- Package reg_file_pkg holds:
  - FSM state enum: ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_DONE=2'd2.
  - Helper function be_merge(old, new, be), returning the byte-merged word.
- One sub-module, reg_file_clr_fsm:
  - Owns state, pointer, busy, clr_done and the write-gate signal.
  - The top owns the array, read muxes and bypass.

Test Plan (default parameters unless stated):
- Reset then write 16'hcdef to addr 3 (be=2'b11), then read ports a=3, b=7 -> d_out_a=16'hcdef, d_out_b=16'h0000.
- Write 16'h4567 to addr 5 while rd_addr a=5 (BYPASS=1) -> d_out_a=16'h4567 in the same cycle. With BYPASS=0 -> 16'h0000 until after the edge.
- Addr 2 holds 16'hba98; write 16'h1234 with be=2'b01 -> addr 2 reads 16'hba34.
- Fill addrs 0..7 with 16'h1111*i, then pulse clr_start:
  - busy high for exactly 8 cycles; clr_done pulses once; all entries then read 0.
  - A write of 16'hffff to addr 1 at sweep cycle 3 -> wr_err next cycle, and addr 1 reads 0 afterwards.
- ZERO_REG=1, NRD=3, write 16'habcd to addr 0 and 16'h00ff to addr 4 -> ports 0,4,0 read 0, 16'h00ff, 0; wr_err stays 0.
- Assert reset at sweep cycle 4 -> busy=0 immediately; all entries 0; no clr_done. A new clr_start after release runs a full 8-cycle sweep.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its clear engine.
package reg_file_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // Widest word the merge helper handles; callers cast down to their own WIDTH.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_BE    = MAX_WIDTH / 8;

  function automatic logic [MAX_WIDTH-1:0] be_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BE-1:0]    be
  );
    logic [MAX_WIDTH-1:0] merged;
    for (int k = 0; k < MAX_BE; k++) begin
      merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear-sweep engine: walks the array one entry per cycle and gates normal writes
// while a sweep (or its completion cycle) is in progress.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          clr_start_i,
  input  logic          wr_i,
  output logic          wr_gate_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_ptr_o,
  output logic          busy_o,
  output logic          clr_done_o,
  output logic          wr_err_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_err_q, wr_err_d;

  // Next-state logic for the sweep and the handshake flags.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_gate_o = 1'b0;
    clr_we_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_gate_o = 1'b1;
        if (clr_start_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_we_o = 1'b1;
        // The last entry is written on this cycle; the pointer never wraps.
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    wr_err_d = wr_i && !wr_gate_o;
  end

  // State and flag registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign clr_ptr_o  = ptr_q;
  assign busy_o     = busy_q;
  assign clr_done_o = done_q;
  assign wr_err_o   = wr_err_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: byte-enable write port, NRD combinational read ports,
// optional write bypass and hardwired-zero entry, plus a sequential clear engine.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     d_in,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] d_out,
  input  logic                 clr_start,
  output logic                 busy,
  output logic                 clr_done,
  output logic                 wr_err
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_gate_s;
  logic             clr_we_s;
  logic [AW-1:0]    clr_ptr_s;
  logic             zero_hit_s;
  logic             wr_ok_s;
  logic [WIDTH-1:0] wr_merged_s;

  reg_file_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk_i       (clk),
    .reset_ni    (reset),
    .clr_start_i (clr_start),
    .wr_i        (wr),
    .wr_gate_o   (wr_gate_s),
    .clr_we_o    (clr_we_s),
    .clr_ptr_o   (clr_ptr_s),
    .busy_o      (busy),
    .clr_done_o  (clr_done),
    .wr_err_o    (wr_err)
  );

  // Writes to the hardwired-zero entry are dropped without flagging an error.
  assign zero_hit_s  = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok_s     = wr && wr_gate_s && !zero_hit_s;
  assign wr_merged_s = WIDTH'(be_merge(MAX_WIDTH'(mem_q[wr_addr]),
                                       MAX_WIDTH'(d_in),
                                       MAX_BE'(wr_be)));

  // Per-entry next value: clear sweep or accepted write, never both at once.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_we_s && (clr_ptr_s == AW'(i))) begin
        mem_d[i] = '0;
      end else if (wr_ok_s && (wr_addr == AW'(i))) begin
        mem_d[i] = wr_merged_s;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Array storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar gp = 0; gp < NRD; gp++) begin : g_rd
    logic [AW-1:0]    addr_s;
    logic [WIDTH-1:0] data_s;

    assign addr_s = rd_addr[gp*AW +: AW];

    // Read mux: zero entry wins over bypass, bypass wins over stored data.
    always_comb begin
      if ((ZERO_REG != 0) && (addr_s == '0)) begin
        data_s = '0;
      end else if ((BYPASS != 0) && wr_ok_s && (addr_s == wr_addr)) begin
        data_s = wr_merged_s;
      end else begin
        data_s = mem_q[addr_s];
      end
    end

    assign d_out[gp*WIDTH +: WIDTH] = data_s;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: a default instance and a ZERO_REG=1/NRD=3/BYPASS=0 instance share stimulus.
module tb_reg_file_mp;

  logic        clk, reset, wr, clr_start;
  logic [2:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] d_in;
  logic [5:0]  rd_addr;
  logic [31:0] d_out;
  logic        busy, clr_done, wr_err;
  logic [8:0]  a_rd_addr;
  logic [47:0] a_d_out;
  logic        a_busy, a_clr_done, a_wr_err;

  reg_file_mp u_dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .wr_be(wr_be), .d_in(d_in),
    .rd_addr(rd_addr), .d_out(d_out), .clr_start(clr_start), .busy(busy),
    .clr_done(clr_done), .wr_err(wr_err)
  );

  reg_file_mp #(.NRD(3), .ZERO_REG(1), .BYPASS(0)) u_alt (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .wr_be(wr_be), .d_in(d_in),
    .rd_addr(a_rd_addr), .d_out(a_d_out), .clr_start(clr_start), .busy(a_busy),
    .clr_done(a_clr_done), .wr_err(a_wr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;

  // Reference model: plain arrays plus a sweep position (0 idle, 1..8 clearing, 9 done).
  logic [15:0] m_mem[8];
  logic [15:0] a_mem[8];
  int          sweep;
  logic        err_m;

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r[7:0]  = be[0] ? n[7:0]  : o[7:0];
    r[15:8] = be[1] ? n[15:8] : o[15:8];
    return r;
  endfunction

  function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "rd_port0";
      1: return "rd_port1";
      2: return "alt_rd_port0";
      3: return "alt_rd_port1";
      4: return "alt_rd_port2";
      5: return "busy";
      6: return "clr_done";
      7: return "wr_err";
      8: return "alt_busy";
      9: return "alt_clr_done";
      default: return "alt_wr_err";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0: return d_out[15:0];
      1: return d_out[31:16];
      2: return a_d_out[15:0];
      3: return a_d_out[31:16];
      4: return a_d_out[47:32];
      5: return {15'd0, busy};
      6: return {15'd0, clr_done};
      7: return {15'd0, wr_err};
      8: return {15'd0, a_busy};
      9: return {15'd0, a_clr_done};
      default: return {15'd0, a_wr_err};
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 16'h0000;
      a_mem[i] = 16'h0000;
    end
    sweep = 0;
    err_m = 1'b0;
  endfunction

  function automatic void push(input int sel, input logic [15:0] v);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    q.push_back(e);
  endfunction

  function automatic void push_expect();
    logic        wok;
    logic [2:0]  ra;
    logic [15:0] mrg;
    wok = reset && wr && (sweep == 0);
    mrg = merge(m_mem[wr_addr], d_in, wr_be);
    for (int p = 0; p < 2; p++) begin
      ra = rd_addr[p*3 +: 3];
      push(p, (wok && ra == wr_addr) ? mrg : m_mem[ra]);
    end
    for (int p = 0; p < 3; p++) begin
      ra = a_rd_addr[p*3 +: 3];
      push(2 + p, (ra == 3'd0) ? 16'h0000 : a_mem[ra]);
    end
    push(5, {15'd0, sweep >= 1 && sweep <= 8});
    push(6, {15'd0, sweep == 9});
    push(7, {15'd0, err_m});
    push(8, {15'd0, sweep >= 1 && sweep <= 8});
    push(9, {15'd0, sweep == 9});
    push(10, {15'd0, err_m});
  endfunction

  function automatic void model_update();
    logic        wok;
    logic [15:0] mm, am;
    wok = wr && (sweep == 0);
    mm  = merge(m_mem[wr_addr], d_in, wr_be);
    am  = merge(a_mem[wr_addr], d_in, wr_be);
    err_m = wr && (sweep != 0);
    if (sweep >= 1 && sweep <= 8) begin
      m_mem[sweep-1] = 16'h0000;
      a_mem[sweep-1] = 16'h0000;
    end
    if (wok) begin
      m_mem[wr_addr] = mm;
      if (wr_addr != 3'd0) a_mem[wr_addr] = am;
    end
    if (sweep == 0) sweep = clr_start ? 1 : 0;
    else if (sweep == 9) sweep = 0;
    else sweep = sweep + 1;
  endfunction

  task automatic step(input logic w, input logic [2:0] wa, input logic [1:0] be,
                      input logic [15:0] din, input logic [2:0] r0, input logic [2:0] r1,
                      input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                      input logic cs);
    wr = w; wr_addr = wa; wr_be = be; d_in = din;
    rd_addr = {r1, r0};
    a_rd_addr = {a2, a1, a0};
    clr_start = cs;
    if (!reset) model_reset();
    push_expect();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'b11, 16'h0000, 3'(i), 3'(i + 1),
                                     3'(i), 3'(i + 2), 3'(i + 4), 1'b0);
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 2'b11, 16'(16'h1111 * i), 3'(i), 3'd0,
                                     3'(i), 3'd4, 3'd0, 1'b0);
  endtask

  // Monitor: drain expectations while outputs are stable, away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        check(sel_name(e.sel), actual(e.sel), e.exp);
      end
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; wr = 1'b0; wr_addr = 3'd0; wr_be = 2'b00; d_in = 16'h0000;
    rd_addr = 6'd0; a_rd_addr = 9'd0; clr_start = 1'b0;
    model_reset();
    @(posedge clk); #1;
    idle(2);
    reset = 1'b1;
    idle(1);

    // Basic write then read of a written and an untouched entry.
    step(1'b1, 3'd3, 2'b11, 16'hcdef, 3'd0, 3'd0, 3'd3, 3'd7, 3'd0, 1'b0);
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd3, 3'd7, 3'd3, 3'd7, 3'd0, 1'b0);
    // Same-cycle bypass (main) versus pre-write value (alt).
    step(1'b1, 3'd5, 2'b11, 16'h4567, 3'd5, 3'd3, 3'd5, 3'd3, 3'd5, 1'b0);
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd5, 3'd3, 3'd5, 3'd3, 3'd5, 1'b0);
    // Byte-enable merge, and an all-disabled write.
    step(1'b1, 3'd2, 2'b11, 16'hba98, 3'd2, 3'd5, 3'd2, 3'd5, 3'd0, 1'b0);
    step(1'b1, 3'd2, 2'b01, 16'h1234, 3'd2, 3'd5, 3'd2, 3'd5, 3'd0, 1'b0);
    step(1'b1, 3'd2, 2'b00, 16'hffff, 3'd2, 3'd3, 3'd2, 3'd3, 3'd0, 1'b0);
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 1'b0);
    // Zero entry on the alt instance.
    step(1'b1, 3'd0, 2'b11, 16'habcd, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 1'b0);
    step(1'b1, 3'd4, 2'b11, 16'h00ff, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 1'b0);
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 1'b0);
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 1'b0);

    // Full sweep with a rejected write at sweep cycle 3.
    fill();
    busy_cnt = 0; done_cnt = 0;
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd1, 3'd7, 3'd1, 3'd7, 3'd4, 1'b1);
    idle(2);
    step(1'b1, 3'd1, 2'b11, 16'hffff, 3'd1, 3'd7, 3'd1, 3'd7, 3'd6, 1'b1);
    idle(9);
    check("busy_cycles", 16'(busy_cnt), 16'd8);
    check("done_pulses", 16'(done_cnt), 16'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 2'b11, 16'h0000, 3'(i), 3'(7 - i),
                                     3'(i), 3'(7 - i), 3'd1, 1'b0);

    // Start and write in the same idle cycle, then a sweep aborted by reset.
    fill();
    busy_cnt = 0; done_cnt = 0;
    step(1'b1, 3'd6, 2'b11, 16'h5a5a, 3'd6, 3'd7, 3'd6, 3'd7, 3'd5, 1'b1);
    idle(3);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(3);
    check("done_after_abort", 16'(done_cnt), 16'd0);
    fill();
    busy_cnt = 0; done_cnt = 0;
    step(1'b0, 3'd0, 2'b11, 16'h0000, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 1'b1);
    idle(10);
    check("busy_cycles_restart", 16'(busy_cnt), 16'd8);
    check("done_pulses_restart", 16'(done_cnt), 16'd1);

    // Randomised traffic with occasional sweeps.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 24) == 0));
    end

    @(negedge clk); #1;
    check("queue_drain", 16'(q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
